// File: rtl/vm_multi.sv
// vm_multi: multi-item vending controller with credit accumulation, per-item prices and a change handshake.
// Optional idle auto-cancel of held credit is enabled by defining VM_MULTI_AUTOCANCEL_EN.
module vm_multi #(
  parameter int unsigned N_ITEMS    = 4,
  parameter int unsigned CW         = 8,
  parameter int unsigned MAX_CREDIT = 50,
  parameter int unsigned COIN1      = 1,
  parameter int unsigned COIN2      = 5,
  parameter int unsigned COIN3      = 10,
  parameter logic [N_ITEMS*CW-1:0] PRICES = {8'd15, 8'd12, 8'd8, 8'd3},
  parameter int unsigned TIMEOUT    = 1000,
  localparam int unsigned IW        = (N_ITEMS > 1) ? $clog2(N_ITEMS) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         coin,
  input  logic [N_ITEMS-1:0] sel,
  input  logic               cancel,
  input  logic               change_ack,
  output logic [CW-1:0]      credit,
  output logic               vend,
  output logic [IW-1:0]      vend_id,
  output logic               nack,
  output logic               coin_rej,
  output logic               change_vld,
  output logic [CW-1:0]      change
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } state_t;

  state_t        state;
  logic [CW-1:0] coin_value;
  logic          coin_in;
  logic [CW:0]   credit_sum;
  logic          coin_fits;
  logic          sel_any;
  logic [IW-1:0] sel_idx;
  logic [CW-1:0] sel_price;
  logic          timeout_c;

  // Coin code to unit value
  always_comb begin
    coin_value = '0;
    case (coin)
      2'b01:   coin_value = CW'(COIN1);
      2'b10:   coin_value = CW'(COIN2);
      2'b11:   coin_value = CW'(COIN3);
      default: coin_value = '0;
    endcase
  end

  assign coin_in    = |coin;
  // One extra bit so the limit check cannot wrap
  assign credit_sum = {1'b0, credit} + {1'b0, coin_value};
  assign coin_fits  = credit_sum <= (CW+1)'(MAX_CREDIT);
  assign sel_any    = |sel;

  // Lowest requested item wins; scanning downward leaves the lowest index last
  always_comb begin
    sel_idx   = '0;
    sel_price = '0;
    for (int i = int'(N_ITEMS) - 1; i >= 0; i--) begin
      if (sel[i]) begin
        sel_idx   = IW'(i);
        sel_price = PRICES[i*CW +: CW];
      end
    end
  end

`ifdef VM_MULTI_AUTOCANCEL_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] idle_cnt;
  logic          activity;

  assign activity  = coin_in | sel_any | cancel;
  // Fires on the TIMEOUT-th consecutive quiet cycle spent holding credit
  assign timeout_c = (state == ST_CREDIT) && !activity && (idle_cnt == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt <= '0;
    end else if (state != ST_CREDIT || activity || timeout_c) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt + TW'(1);
    end
  end
`else
  logic unused_timeout;

  assign timeout_c      = 1'b0;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Controller state and all registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      credit     <= '0;
      vend       <= 1'b0;
      vend_id    <= '0;
      nack       <= 1'b0;
      coin_rej   <= 1'b0;
      change_vld <= 1'b0;
      change     <= '0;
    end else begin
      vend     <= 1'b0;
      nack     <= 1'b0;
      coin_rej <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (coin_in) begin
            if (coin_fits) begin
              credit <= coin_value;
              state  <= ST_CREDIT;
            end else begin
              coin_rej <= 1'b1;
            end
          end
        end
        ST_CREDIT: begin
          if (cancel || timeout_c) begin
            coin_rej   <= coin_in;
            change     <= credit;
            change_vld <= 1'b1;
            state      <= ST_CHANGE;
          end else if (sel_any) begin
            coin_rej <= coin_in;
            if (credit >= sel_price) begin
              credit  <= credit - sel_price;
              vend    <= 1'b1;
              vend_id <= sel_idx;
              state   <= ST_VEND;
            end else begin
              nack <= 1'b1;
            end
          end else if (coin_in) begin
            if (coin_fits) begin
              credit <= credit_sum[CW-1:0];
            end else begin
              coin_rej <= 1'b1;
            end
          end
        end
        ST_VEND: begin
          coin_rej <= coin_in;
          if (credit != '0) begin
            change     <= credit;
            change_vld <= 1'b1;
            state      <= ST_CHANGE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_CHANGE: begin
          coin_rej <= coin_in;
          if (change_ack) begin
            change_vld <= 1'b0;
            change     <= '0;
            credit     <= '0;
            state      <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vm_multi.sv
// tb_vm_multi: directed bench for vm_multi with a per-cycle reference model and literal spot checks.
module tb_vm_multi;

  localparam int unsigned MAXC       = 50;
  localparam int unsigned TB_TIMEOUT = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] coin = '0;
  logic [3:0] sel = '0;
  logic       cancel = 1'b0;
  logic       change_ack = 1'b0;
  logic [7:0] credit;
  logic       vend;
  logic [1:0] vend_id;
  logic       nack;
  logic       coin_rej;
  logic       change_vld;
  logic [7:0] change;

  int checks = 0;
  int errors = 0;

  int price_tbl [4] = '{3, 8, 12, 15};
  int coin_tbl  [4] = '{0, 1, 5, 10};

  // Expected outputs after the most recent edge
  int e_credit = 0;
  int e_vend_id = 0;
  int e_change = 0;
  bit e_vend = 0;
  bit e_nack = 0;
  bit e_rej = 0;
  bit e_cvld = 0;
  int idle_run = 0;
  bit check_en = 0;

  vm_multi #(.TIMEOUT(TB_TIMEOUT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .coin       (coin),
    .sel        (sel),
    .cancel     (cancel),
    .change_ack (change_ack),
    .credit     (credit),
    .vend       (vend),
    .vend_id    (vend_id),
    .nack       (nack),
    .coin_rej   (coin_rej),
    .change_vld (change_vld),
    .change     (change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    e_credit  = 0;
    e_vend_id = 0;
    e_change  = 0;
    e_vend    = 0;
    e_nack    = 0;
    e_rej     = 0;
    e_cvld    = 0;
    idle_run  = 0;
  endtask

  // Machine is "holding credit" whenever credit is nonzero and no vend/change is in flight
  task automatic model_edge(input logic [1:0] c, input logic [3:0] s, input logic x, input logic a);
    int v;
    int lo;
    bit was_vend;
    bit was_change;
    bit timed_out;
    v = coin_tbl[c];
    lo = -1;
    for (int i = 3; i >= 0; i--) if (s[i]) lo = i;
    was_vend   = e_vend;
    was_change = e_cvld;
    timed_out  = 0;
    e_vend = 0;
    e_nack = 0;
    e_rej  = 0;
    if (was_change) begin
      idle_run = 0;
      e_rej = (c != 0);
      if (a) begin
        e_cvld   = 0;
        e_credit = 0;
        e_change = 0;
      end
    end else if (was_vend) begin
      idle_run = 0;
      e_rej = (c != 0);
      if (e_credit > 0) begin
        e_cvld   = 1;
        e_change = e_credit;
      end
    end else if (e_credit == 0) begin
      idle_run = 0;
      if (c != 0) begin
        if (v <= MAXC) e_credit = v;
        else e_rej = 1;
      end
    end else begin
`ifdef VM_MULTI_AUTOCANCEL_EN
      if (c == 0 && s == 0 && !x) begin
        idle_run++;
        timed_out = (idle_run >= TB_TIMEOUT);
      end else begin
        idle_run = 0;
      end
`endif
      if (x || timed_out) begin
        e_rej    = (c != 0);
        e_cvld   = 1;
        e_change = e_credit;
        idle_run = 0;
      end else if (lo >= 0) begin
        e_rej = (c != 0);
        if (e_credit >= price_tbl[lo]) begin
          e_credit  = e_credit - price_tbl[lo];
          e_vend    = 1;
          e_vend_id = lo;
        end else begin
          e_nack = 1;
        end
      end else if (c != 0) begin
        if (e_credit + v <= MAXC) e_credit = e_credit + v;
        else e_rej = 1;
      end
    end
  endtask

  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_edge(coin, sel, cancel, change_ack);
  end

  // Per-cycle comparison against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("credit", credit, e_credit);
      chk("vend", vend, e_vend);
      if (e_vend) chk("vend_id", vend_id, e_vend_id);
      chk("nack", nack, e_nack);
      chk("coin_rej", coin_rej, e_rej);
      chk("change_vld", change_vld, e_cvld);
      if (e_cvld) chk("change", change, e_change);
    end
  end

  // Drive one cycle of inputs starting at a falling edge; returns at the next falling edge
  task automatic step(input logic [1:0] c, input logic [3:0] s, input logic x, input logic a);
    coin = c;
    sel = s;
    cancel = x;
    change_ack = a;
    @(negedge clk);
    coin = '0;
    sel = '0;
    cancel = 1'b0;
    change_ack = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_credit", credit, 0);
    chk("rst_vend", vend, 0);
    chk("rst_change_vld", change_vld, 0);
    chk("rst_coin_rej", coin_rej, 0);
    rst_n = 1'b1;
    check_en = 1'b1;

    // Purchase with change
    step(2'b11, 4'b0000, 0, 0); chk("t1_credit10", credit, 10);
    step(2'b10, 4'b0000, 0, 0); chk("t1_credit15", credit, 15);
    step(2'b00, 4'b0100, 0, 0);
    chk("t1_vend", vend, 1); chk("t1_vend_id", vend_id, 2); chk("t1_credit3", credit, 3);
    step(2'b00, 4'b0000, 0, 0);
    chk("t1_cvld", change_vld, 1); chk("t1_change", change, 3); chk("t1_vend_off", vend, 0);
    step(2'b00, 4'b0001, 1, 0);
    chk("t1_hold_vld", change_vld, 1); chk("t1_hold_change", change, 3);
    step(2'b00, 4'b0000, 0, 1);
    chk("t1_ack_vld", change_vld, 0); chk("t1_ack_credit", credit, 0);
    step(2'b00, 4'b0001, 1, 1);
    chk("idle_ignore_vend", vend, 0); chk("idle_ignore_vld", change_vld, 0); chk("idle_ignore_nack", nack, 0);

    // Insufficient credit, then cancel
    step(2'b01, 4'b0000, 0, 0); chk("t2_credit1", credit, 1);
    step(2'b00, 4'b1000, 0, 0); chk("t2_nack", nack, 1); chk("t2_credit1b", credit, 1);
    step(2'b00, 4'b0000, 0, 0); chk("t2_nack_off", nack, 0);
    step(2'b00, 4'b0000, 1, 0); chk("t2_cvld", change_vld, 1); chk("t2_change", change, 1);
    step(2'b00, 4'b0000, 0, 1); chk("t2_ack", change_vld, 0);

    // Credit ceiling
    repeat (5) step(2'b11, 4'b0000, 0, 0);
    chk("t3_credit50", credit, 50);
    step(2'b01, 4'b0000, 0, 0); chk("t3_rej", coin_rej, 1); chk("t3_credit50b", credit, 50);
    step(2'b00, 4'b0001, 0, 0); chk("t3_vend", vend, 1); chk("t3_vend_id", vend_id, 0);
    step(2'b00, 4'b0000, 0, 0); chk("t3_change", change, 47); chk("t3_cvld", change_vld, 1);
    step(2'b00, 4'b0000, 0, 1);

    // Exact payment returns straight to idle
    step(2'b10, 4'b0000, 0, 0);
    step(2'b01, 4'b0000, 0, 0);
    step(2'b01, 4'b0000, 0, 0);
    step(2'b01, 4'b0000, 0, 0); chk("t4_credit8", credit, 8);
    step(2'b00, 4'b0010, 0, 0); chk("t4_vend_id", vend_id, 1); chk("t4_credit0", credit, 0);
    step(2'b00, 4'b0000, 0, 0); chk("t4_no_change", change_vld, 0);
    step(2'b01, 4'b0000, 0, 0); chk("t4_idle_coin", credit, 1);
    step(2'b00, 4'b0000, 1, 0);
    step(2'b00, 4'b0000, 0, 1);

    // Multi-bit select with a simultaneous coin, and coins during VEND/CHANGE
    step(2'b11, 4'b0000, 0, 0);
    step(2'b11, 4'b0000, 0, 0); chk("t5_credit20", credit, 20);
    step(2'b11, 4'b0110, 0, 0);
    chk("t5_vend", vend, 1); chk("t5_vend_id", vend_id, 1); chk("t5_rej", coin_rej, 1); chk("t5_credit12", credit, 12);
    step(2'b01, 4'b0000, 0, 0); chk("t5_vend_rej", coin_rej, 1); chk("t5_change", change, 12);
    step(2'b10, 4'b0000, 0, 0); chk("t5_chg_rej", coin_rej, 1); chk("t5_chg_hold", change, 12);
    step(2'b00, 4'b0000, 0, 1); chk("t5_ack", change_vld, 0); chk("t5_credit0", credit, 0);

    // Idle hold for twice the timeout
    step(2'b10, 4'b0000, 0, 0); chk("t6_credit5", credit, 5);
    repeat (2 * TB_TIMEOUT) step(2'b00, 4'b0000, 0, 0);
`ifdef VM_MULTI_AUTOCANCEL_EN
    chk("t6_auto_vld", change_vld, 1); chk("t6_auto_change", change, 5);
    step(2'b00, 4'b0000, 0, 1);
`else
    chk("t6_held_credit", credit, 5); chk("t6_no_change", change_vld, 0);
    step(2'b00, 4'b0000, 1, 0);
    step(2'b00, 4'b0000, 0, 1);
`endif

    // Asynchronous reset while change is pending
    step(2'b11, 4'b0000, 0, 0);
    step(2'b00, 4'b0000, 1, 0); chk("t7_cvld", change_vld, 1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("t7_rst_credit", credit, 0);
    chk("t7_rst_vld", change_vld, 0);
    chk("t7_rst_change", change, 0);
    chk("t7_rst_vend", vend, 0);
    chk("t7_rst_vend_id", vend_id, 0);
    chk("t7_rst_nack", nack, 0);
    chk("t7_rst_rej", coin_rej, 0);
    @(negedge clk);
    rst_n = 1'b1;
    step(2'b00, 4'b0000, 0, 0);
    step(2'b01, 4'b0000, 0, 0); chk("t7_post_credit", credit, 1);
    step(2'b00, 4'b0000, 1, 0);
    step(2'b00, 4'b0000, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
